// File: rtl/log_packet_framer.sv
// Packs an upstream log byte stream into frames of MAGIC, sequence, {trunc, length} and payload.
// Packets longer than MAX_LENGTH are cut short, and the rest of that packet is dropped.
module log_packet_framer #(
  parameter int          MAX_LENGTH = 32,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic       s_tkeep,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tkeep,
  output logic [7:0] m_tdata,
  output logic [7:0] seq_o,
  output logic       trunc_o
);

  localparam int CW = $clog2(MAX_LENGTH + 1);
  localparam int AW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;

  typedef enum logic [1:0] {FILL, DISC, HEAD, BODY} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [CW-1:0]  rd_idx;
  logic [1:0]     hdr_idx;
  logic           trunc_flag;
  logic [7:0]     buffer [MAX_LENGTH];

  logic           store;
  logic [CW-1:0]  count_next;
  logic [6:0]     count7;

  assign s_tready   = (state == FILL) || (state == DISC);
  assign m_tkeep    = m_tvalid;
  assign store      = s_tvalid && s_tkeep && (state == FILL);
  assign count_next = count + CW'(store);
  assign count7     = 7'(count);

  // NOTE: storage arrays carry no reset; count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (store) buffer[count[AW-1:0]] <= s_tdata;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FILL;
      count      <= '0;
      rd_idx     <= '0;
      hdr_idx    <= '0;
      trunc_flag <= 1'b0;
      trunc_o    <= 1'b0;
      seq_o      <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
    end else begin
      trunc_o <= 1'b0;
      unique case (state)
        FILL: begin
          if (s_tvalid) begin
            if (s_tlast) begin
              // A packet of only null beats leaves count at zero and produces no frame.
              if (count_next != '0) begin
                state      <= HEAD;
                count      <= count_next;
                trunc_flag <= 1'b0;
                m_tvalid   <= 1'b1;
                m_tdata    <= MAGIC;
                hdr_idx    <= '0;
              end
            end else if (store && count_next == CW'(MAX_LENGTH)) begin
              state      <= DISC;
              count      <= count_next;
              trunc_flag <= 1'b1;
              trunc_o    <= 1'b1;
            end else begin
              count <= count_next;
            end
          end
        end
        DISC: begin
          if (s_tvalid && s_tlast) begin
            state    <= HEAD;
            m_tvalid <= 1'b1;
            m_tdata  <= MAGIC;
            hdr_idx  <= '0;
          end
        end
        HEAD: begin
          if (m_tready) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0:    m_tdata <= seq_o;
              2'd1:    m_tdata <= {trunc_flag, count7};
              default: begin
                state   <= BODY;
                m_tdata <= buffer[0];
                m_tlast <= (count == CW'(1));
                rd_idx  <= CW'(1);
              end
            endcase
          end
        end
        BODY: begin
          if (m_tready) begin
            if (m_tlast) begin
              state    <= FILL;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              m_tdata  <= '0;
              count    <= '0;
              seq_o    <= seq_o + 8'd1;
            end else begin
              m_tdata <= buffer[rd_idx[AW-1:0]];
              m_tlast <= (rd_idx == count - CW'(1));
              rd_idx  <= rd_idx + CW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_log_packet_framer.sv
// Self-checking bench for log_packet_framer: a packet-level reference model feeds an expected-byte
// queue, and a negedge monitor checks every output byte, the stall stability and seq_o.
module tb_log_packet_framer;
  localparam int MAX = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tkeep = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tready;
  logic       m_tvalid, m_tready, m_tlast, m_tkeep;
  logic [7:0] m_tdata, seq_o;
  logic       trunc_o;

  logic fixed_ready = 1'b1, rand_ready = 1'b0, rnd_ready = 1'b0;
  assign m_tready = rand_ready ? rnd_ready : fixed_ready;

  log_packet_framer #(.MAX_LENGTH(MAX), .MAGIC(8'hA5)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tkeep(m_tkeep), .m_tdata(m_tdata),
    .seq_o(seq_o), .trunc_o(trunc_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  int tests = 0, fails = 0;
  logic [8:0] exp_q[$];   // {last, data} expected from the model
  logic [8:0] obs_q[$];   // {last, data} actually handshaken
  logic [8:0] lit[$];     // hand-computed literal frames
  int model_seq = 0, exp_seq = 0, exp_trunc = 0, trunc_seen = 0;
  logic [7:0] pkt_data[64];
  bit         pkt_keep[64];
  int         pkt_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge so values are settled.
  bit stalled = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clock) begin
    if (reset) begin
      exp_seq = 0;
      stalled = 1'b0;
    end else begin
      check("m_tkeep_eq_tvalid", m_tkeep, m_tvalid);
      check("seq_o", seq_o, 32'(exp_seq));
      if (trunc_o) trunc_seen++;
      if (stalled && m_tvalid) check("stall_hold", {m_tlast, m_tdata}, held);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h, expected no output (t=%0t)", {m_tlast, m_tdata}, $time);
        end else begin
          check("m_byte", {m_tlast, m_tdata}, exp_q.pop_front());
        end
        obs_q.push_back({m_tlast, m_tdata});
        if (m_tlast) exp_seq = (exp_seq + 1) % 256;
      end
      stalled = m_tvalid && !m_tready;
      held    = {m_tlast, m_tdata};
    end
  end

  task automatic wait_accept();
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 5000) begin
      @(negedge clock);
      ok = s_tready;
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: s_tready stayed 0 for %0d cycles", n);
    end
    @(posedge clock);
    #1;
  endtask

  // Model: what frame (if any) this packet must produce, then drive its beats.
  task automatic send_pkt(input bit gaps);
    logic [7:0] pay[$];
    bit tr = 1'b0;
    for (int i = 0; i < pkt_len; i++) begin
      if (!tr && pkt_keep[i]) begin
        pay.push_back(pkt_data[i]);
        if (pay.size() == MAX && i != pkt_len - 1) tr = 1'b1;
      end
    end
    if (pay.size() > 0) begin
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, 8'(model_seq)});
      exp_q.push_back({1'b0, tr, 7'(pay.size())});
      for (int i = 0; i < pay.size(); i++) exp_q.push_back({i == pay.size() - 1, pay[i]});
      model_seq = (model_seq + 1) % 256;
      if (tr) exp_trunc++;
    end
    for (int i = 0; i < pkt_len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = pkt_data[i];
      s_tkeep  = pkt_keep[i];
      s_tlast  = (i == pkt_len - 1);
      wait_accept();
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
        @(posedge clock);
        #1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    s_tvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    model_seq  = 0;
    exp_trunc  = 0;
    trunc_seen = 0;
  endtask

  task automatic check_obs(input string name);
    check({name, "_len"}, obs_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs_q.size(); i++) check(name, obs_q[i], lit[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    @(negedge clock);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_seq_o", seq_o, 0);
    check("rst_trunc_o", trunc_o, 0);
    check("rst_s_tready", s_tready, 1);
    @(posedge clock);
    #1;

    // Null-only packet: no frame, seq unchanged; then a 1-byte packet.
    pkt_len = 3;
    for (int i = 0; i < 3; i++) begin pkt_data[i] = 8'(8'h10 + i); pkt_keep[i] = 1'b0; end
    send_pkt(1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("empty_no_output", obs_q.size(), 0);
    check("empty_seq", seq_o, 0);
    pkt_len = 1; pkt_data[0] = 8'h55; pkt_keep[0] = 1'b1;
    send_pkt(1'b0);
    drain();
    lit = '{9'h0A5, 9'h000, 9'h001, 9'h155};
    check_obs("one_byte_frame");

    // Basic 4-byte packet.
    apply_reset();
    pkt_len = 4;
    for (int i = 0; i < 4; i++) begin pkt_data[i] = 8'(i + 1); pkt_keep[i] = 1'b1; end
    send_pkt(1'b0);
    drain();
    lit = '{9'h0A5, 9'h000, 9'h004, 9'h001, 9'h002, 9'h003, 9'h104};
    check_obs("four_byte_frame");
    check("four_byte_seq", seq_o, 1);

    // 40-byte packet truncated to MAX.
    apply_reset();
    pkt_len = 40;
    for (int i = 0; i < 40; i++) begin pkt_data[i] = 8'(i); pkt_keep[i] = 1'b1; end
    send_pkt(1'b0);
    drain();
    lit = '{9'h0A5, 9'h000, 9'h0A0};
    for (int i = 0; i < MAX; i++) lit.push_back({i == MAX - 1, 8'(i)});
    check_obs("trunc_frame");
    check("trunc_pulses", trunc_seen, 1);

    // Sequence wrap over 256 frames, then one more.
    apply_reset();
    for (int k = 0; k < 256; k++) begin
      pkt_len = 1; pkt_data[0] = 8'($urandom); pkt_keep[0] = 1'b1;
      send_pkt(1'b0);
    end
    drain();
    check("seq_wrap", seq_o, 0);
    obs_q.delete();
    pkt_len = 1; pkt_data[0] = 8'h3C; pkt_keep[0] = 1'b1;
    send_pkt(1'b0);
    drain();
    lit = '{9'h0A5, 9'h000, 9'h001, 9'h13C};
    check_obs("after_wrap_frame");

    // Reset during BODY after two payload bytes.
    apply_reset();
    pkt_len = 6;
    for (int i = 0; i < 6; i++) begin pkt_data[i] = 8'(8'hC0 + i); pkt_keep[i] = 1'b1; end
    send_pkt(1'b0);
    begin
      int n = 0;
      while (obs_q.size() < 5 && n < 200) begin
        @(posedge clock);
        #1;
        n++;
      end
      check("midframe_reached", obs_q.size(), 5);
    end
    fixed_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_seq_o", seq_o, 0);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    model_seq = 0;
    fixed_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("midrst_no_residue", obs_q.size(), 0);
    pkt_len = 1; pkt_data[0] = 8'h77; pkt_keep[0] = 1'b1;
    send_pkt(1'b0);
    drain();
    lit = '{9'h0A5, 9'h000, 9'h001, 9'h177};
    check_obs("post_rst_frame");

    // Random packets under 50% backpressure.
    apply_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      int sel = $urandom_range(0, 9);
      bit null_pkt = ($urandom_range(0, 19) == 0);
      pkt_len = (sel == 0) ? MAX : (sel == 1) ? MAX + 1 : $urandom_range(1, 45);
      for (int i = 0; i < pkt_len; i++) begin
        pkt_data[i] = 8'($urandom);
        pkt_keep[i] = !null_pkt && ($urandom_range(0, 9) != 0);
      end
      send_pkt(1'b1);
    end
    drain();
    rand_ready = 1'b0;
    check("random_trunc_pulses", trunc_seen, exp_trunc);
    check("random_final_seq", seq_o, 32'(model_seq));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
